uart_serdes: RTL
================

UART_SERDES -- requirements
Module: uart_serdes

Interface
REQ-001 Parameter freq_hz, default 100000000: clock frequency in Hz.
REQ-002 Parameter baud, default 115200: line rate in bit/s.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 uart_rxd  input  1  serial receive line, asynchronous to clk, idle high.
REQ-006 uart_txd  output  1  serial transmit line, idle high.
REQ-007 rx_data  output  8  last correctly framed received byte.
REQ-008 rx_avail  output  1  unread byte held in rx_data.
REQ-009 rx_error  output  1  framing error or overrun since last rx_ack.
REQ-010 rx_ack  input  1  one-cycle pulse; consumer has read rx_data.
REQ-011 tx_data  input  8  byte to send, sampled on accepted tx_wr.
REQ-012 tx_wr  input  1  one-cycle pulse; start transmission.
REQ-013 tx_busy  output  1  transmitter occupied; tx_wr ignored while high.

Function
REQ-014 Oversample tick SHALL pulse one cycle every DIV = max(1, floor(freq_hz/(16*baud))) clocks, free-running after reset; one bit = 16 ticks.
REQ-015 uart_rxd SHALL pass through a 2-flop synchronizer before use; RX latency to the FSM is 2 cycles.
REQ-016 RX FSM states IDLE, START, DATA, STOP, WAIT_HIGH; IDLE -> START on synchronized low.
REQ-017 START: after 8 ticks resample; high -> IDLE (glitch, nothing reported), low -> DATA.
REQ-018 DATA: sample every 16 ticks, 8 bits, LSB first, into a shift register; then -> STOP.
REQ-019 STOP: sample after 16 ticks; high -> load rx_data, set rx_avail, -> IDLE; low -> set rx_error, rx_data unchanged, -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE on first synchronized high sample.
REQ-021 Overrun: good frame completing while rx_avail=1 SHALL overwrite rx_data, keep rx_avail=1, set rx_error.
REQ-022 rx_ack SHALL clear rx_avail and rx_error the following cycle.
REQ-023 rx_ack coinciding with a frame completion: completion wins (rx_avail=1, new rx_data, rx_error per REQ-019/021 ignoring the ack).
REQ-024 TX FSM states IDLE, START, DATA, STOP; each state bit lasts 16 ticks; data LSB first.
REQ-025 tx_wr with tx_busy=0 SHALL latch tx_data and raise tx_busy the next cycle; START begins at the next tick.
REQ-026 tx_wr with tx_busy=1 SHALL be ignored, no state change.
REQ-027 tx_busy SHALL fall the cycle after the stop bit's 16th tick; back-to-back tx_wr accepted that cycle.
REQ-028 uart_txd SHALL be registered (glitch-free), high in IDLE and STOP.

Reset
REQ-029 While reset=0: uart_txd=1, tx_busy=0, rx_avail=0, rx_error=0, rx_data=0x00, both FSMs IDLE, tick counter 0, synchronizer flops 1.
REQ-030 Reset mid-frame SHALL abort both directions immediately; no partial byte reported after release.

Structure
REQ-031 Package uart_pkg SHALL hold RX/TX state enums and constant OVERSAMPLE=16.
REQ-032 Sub-module uart_baud_gen SHALL implement REQ-014; RX and TX FSMs stay in uart_serdes.

Verification (freq_hz=18432000, baud=115200 -> DIV=10, bit=160 clk)
REQ-033 tx_wr, tx_data=0x55 -> uart_txd low 160 clk, then 1,0,1,0,1,0,1,0 each 160 clk, high 160 clk; tx_busy high approx. 1600 clk; second tx_wr mid-frame ignored.
REQ-034 Drive frame 0xA3 with good stop -> rx_avail=1, rx_data=0xA3, rx_error=0; rx_ack -> rx_avail=0 next cycle.
REQ-035 Frame 0x7E with stop bit low -> rx_error=1, rx_avail=0, rx_data unchanged; next good frame 0x12 received after line returns high.
REQ-036 Frames 0x11 then 0x3C without rx_ack -> rx_data=0x3C, rx_avail=1, rx_error=1; rx_ack clears both.
REQ-037 uart_rxd low for 40 clk then high -> no rx_avail, no rx_error; following frame 0x5A received correctly.
REQ-038 reset=0 at bit 3 of a TX frame -> uart_txd=1 and tx_busy=0 without waiting for a clock edge; first tx_wr after release sends a full correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART serializer/deserializer.
//   OVERSAMPLE : oversample ticks per bit
//   rx_state_e : receive FSM states
//   tx_state_e : transmit FSM states
//   calc_div   : clocks per oversample tick, never less than 1
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic int calc_div(input int f_hz, input int b);
    int d;
    d = f_hz / (OVERSAMPLE * b);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator.
//   clk    : clock
//   reset  : async active-low reset, counter returns to 0
//   o_tick : one-cycle pulse every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  // With DIV == 1 the compare is always true and the counter sits at 0.
  assign w_tick = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_serdes.sv
// 8N1 UART transmitter and receiver sharing one oversample tick.
//   clk, reset : clock, async active-low reset
//   uart_rxd   : serial input (async, idle high)
//   uart_txd   : serial output (registered, idle high)
//   rx_data    : last well-framed received byte
//   rx_avail   : unread byte present
//   rx_error   : framing error or overrun since last rx_ack
//   rx_ack     : consumer read pulse
//   tx_data    : byte to send, latched on accepted tx_wr
//   tx_wr      : send request pulse
//   tx_busy    : transmitter occupied, tx_wr ignored
module uart_serdes
  import uart_pkg::*;
#(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int DIV = calc_div(freq_hz, baud);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);

  logic w_tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // ---------------- receive ----------------
  logic [1:0] r_sync;
  logic       w_rxd;
  rx_state_e  r_rx_state;
  logic [3:0] r_rx_tcnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_avail;
  logic       r_rx_error;

  assign w_rxd = r_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], uart_rxd};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_avail <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      // The ack is applied first so a completing frame in the same cycle wins.
      if (rx_ack) begin
        r_rx_avail <= 1'b0;
        r_rx_error <= 1'b0;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxd) begin
            r_rx_state <= RX_START;
            r_rx_tcnt  <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_tcnt == HALF_TICK) begin
              // Mid-start resample: a high line here was only a glitch.
              r_rx_tcnt  <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
            if (r_rx_tcnt == LAST_TICK) begin
              r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
              r_rx_bit   <= r_rx_bit + 1'b1;
              if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
            if (r_rx_tcnt == LAST_TICK) begin
              if (w_rxd) begin
                r_rx_data  <= r_rx_shift;
                r_rx_avail <= 1'b1;
                // Overrun judged on the pre-ack flag.
                if (r_rx_avail) r_rx_error <= 1'b1;
                r_rx_state <= RX_IDLE;
              end else begin
                r_rx_error <= 1'b1;
                r_rx_state <= RX_WAIT_HIGH;
              end
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (w_rxd) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_avail = r_rx_avail;
  assign rx_error = r_rx_error;

  // ---------------- transmit ----------------
  tx_state_e  r_tx_state;
  logic [3:0] r_tx_tcnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic       r_tx_busy;
  logic       r_txd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_busy  <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (r_tx_busy) begin
            // Byte latched; start bit is aligned to the next tick.
            if (w_tick) begin
              r_tx_state <= TX_START;
              r_tx_tcnt  <= '0;
              r_txd      <= 1'b0;
            end
          end else if (tx_wr) begin
            r_tx_shift <= tx_data;
            r_tx_busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
            if (r_tx_tcnt == LAST_TICK) begin
              r_tx_state <= TX_DATA;
              r_tx_bit   <= '0;
              r_txd      <= r_tx_shift[0];
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
            if (r_tx_tcnt == LAST_TICK) begin
              if (r_tx_bit == 3'd7) begin
                r_tx_state <= TX_STOP;
                r_txd      <= 1'b1;
              end else begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_txd      <= r_tx_shift[1];
                r_tx_bit   <= r_tx_bit + 1'b1;
              end
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
            if (r_tx_tcnt == LAST_TICK) begin
              r_tx_state <= TX_IDLE;
              r_tx_busy  <= 1'b0;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;
  assign tx_busy  = r_tx_busy;

endmodule
